// File: rtl/wd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wd_pkg : shared defaults, FSM encoding and source indices for wd_select_sync
// Rev 1.0
// ----------------------------------------------------------------------------
package wd_pkg;

    localparam int WD_WIDTH_DEF   = 32;
    localparam int WD_N_SRC_DEF   = 8;
    localparam int WD_TIMEOUT_DEF = 64;

    typedef enum logic [0:0] {
        WD_IDLE = 1'b0,
        WD_WAIT = 1'b1
    } wd_state_t;

    // Datapath result sources as wired to the register-file write port
    localparam int SRC_ALU   = 0;
    localparam int SRC_MEM   = 1;
    localparam int SRC_HI    = 2;
    localparam int SRC_LO    = 3;
    localparam int SRC_SHIFT = 4;
    localparam int SRC_PC    = 5;
    localparam int SRC_IMM   = 6;
    localparam int SRC_LT    = 7;

endpackage
`default_nettype wire

// File: rtl/mux_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux_n : N-way combinational mux over a flattened bus, zero when out of range
// Rev 1.0
// ----------------------------------------------------------------------------
module mux_n #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 8,
    parameter int SEL_W = $clog2(N_SRC)
) (
    input  logic [N_SRC*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       data_out
);

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                data_out = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wd_select_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wd_select_sync : waits for the selected source to be valid, then registers
//                  its data with a one-cycle register-file write strobe
// Rev 1.0
// ----------------------------------------------------------------------------
module wd_select_sync
    import wd_pkg::*;
#(
    parameter int WIDTH   = WD_WIDTH_DEF,
    parameter int N_SRC   = WD_N_SRC_DEF,
    parameter int SEL_W   = $clog2(N_SRC),
    parameter int TIMEOUT = WD_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [SEL_W-1:0]       req_sel,
    output logic                   req_ready,
    input  logic                   flush,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_valid,
    output logic [WIDTH-1:0]       wd_data,
    output logic                   wd_valid,
    output logic                   busy,
    output logic                   err_sel,
    output logic                   err_timeout
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(N_SRC);

    wd_state_t        state;
    wd_state_t        state_nxt;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] mux_data;
    logic [WIDTH-1:0] data_nxt;
    logic             sel_vld;
    logic             sel_illegal;
    logic             wd_valid_nxt;
    logic             err_sel_nxt;
    logic             err_timeout_nxt;

    mux_n #(
        .WIDTH (WIDTH),
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_data_mux (
        .data_in  (src_data),
        .sel      (sel_q),
        .data_out (mux_data)
    );

    assign sel_vld     = src_valid[sel_q];
    assign sel_illegal = ({1'b0, req_sel} >= SEL_LIMIT);
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign req_ready   = (state == WD_IDLE);
    assign busy        = (state == WD_WAIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= WD_IDLE;
            sel_q       <= '0;
            cnt         <= '0;
            wd_data     <= '0;
            wd_valid    <= 1'b0;
            err_sel     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel_q       <= sel_nxt;
            cnt         <= cnt_nxt;
            wd_data     <= data_nxt;
            wd_valid    <= wd_valid_nxt;
            err_sel     <= err_sel_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

    // Flush beats capture, and capture beats timeout in the last WAIT cycle
    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel_q;
        cnt_nxt         = cnt;
        data_nxt        = wd_data;
        wd_valid_nxt    = 1'b0;
        err_sel_nxt     = 1'b0;
        err_timeout_nxt = 1'b0;
        case (state)
            WD_IDLE: begin
                if (!flush && req_valid) begin
                    if (sel_illegal) begin
                        err_sel_nxt = 1'b1;
                    end else begin
                        sel_nxt   = req_sel;
                        cnt_nxt   = '0;
                        state_nxt = WD_WAIT;
                    end
                end
            end
            WD_WAIT: begin
                cnt_nxt = cnt_inc;
                if (flush) begin
                    state_nxt = WD_IDLE;
                end else if (sel_vld) begin
                    data_nxt     = mux_data;
                    wd_valid_nxt = 1'b1;
                    state_nxt    = WD_IDLE;
                end else if (cnt_inc == CNT_MAX) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = WD_IDLE;
                end
            end
            default: begin
                state_nxt = WD_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wd_select_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wd_select_sync : scoreboard bench, default instance plus a small
//                     N_SRC=6 / TIMEOUT=4 instance
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_wd_select_sync;
    import wd_pkg::*;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] data;
        int          at;
    } exp_t;

    localparam logic [2:0] K_WD = 3'b001;
    localparam logic [2:0] K_ES = 3'b010;
    localparam logic [2:0] K_ET = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];

    // instance a: defaults
    logic         reset_a, req_valid_a, req_ready_a, flush_a;
    logic [2:0]   req_sel_a;
    logic [255:0] src_data_a;
    logic [7:0]   src_valid_a;
    logic [31:0]  wd_data_a;
    logic         wd_valid_a, busy_a, err_sel_a, err_timeout_a;

    // instance b: six sources, short timeout
    logic         reset_b, req_valid_b, req_ready_b, flush_b;
    logic [2:0]   req_sel_b;
    logic [191:0] src_data_b;
    logic [5:0]   src_valid_b;
    logic [31:0]  wd_data_b;
    logic         wd_valid_b, busy_b, err_sel_b, err_timeout_b;

    wd_select_sync u_dut_a (
        .clk (clk), .reset (reset_a), .req_valid (req_valid_a), .req_sel (req_sel_a),
        .req_ready (req_ready_a), .flush (flush_a), .src_data (src_data_a),
        .src_valid (src_valid_a), .wd_data (wd_data_a), .wd_valid (wd_valid_a),
        .busy (busy_a), .err_sel (err_sel_a), .err_timeout (err_timeout_a)
    );

    wd_select_sync #(.WIDTH(32), .N_SRC(6), .TIMEOUT(4)) u_dut_b (
        .clk (clk), .reset (reset_b), .req_valid (req_valid_b), .req_sel (req_sel_b),
        .req_ready (req_ready_b), .flush (flush_b), .src_data (src_data_b),
        .src_valid (src_valid_b), .wd_data (wd_data_b), .wd_valid (wd_valid_b),
        .busy (busy_b), .err_sel (err_sel_b), .err_timeout (err_timeout_b)
    );

    task automatic mon_step(input int id, input logic [2:0] flags, input logic [31:0] d);
        exp_t e;
        bit   have;
        if (id == 0) begin
            have = (qa.size() > 0);
            if (have) e = qa[0];
        end else begin
            have = (qb.size() > 0);
            if (have) e = qb[0];
        end
        if (flags != 3'b000) begin
            n_cmp++;
            if (!have) begin
                n_bad++;
                $display("FAIL dut%0d unexpected output: flags=%b data=%h cyc=%0d, required no output",
                         id, flags, d, cyc);
            end else begin
                if (id == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                if (flags !== e.kind || d !== e.data || cyc != e.at) begin
                    n_bad++;
                    $display("FAIL dut%0d output: got flags=%b data=%h cyc=%0d, required flags=%b data=%h cyc=%0d",
                             id, flags, d, cyc, e.kind, e.data, e.at);
                end
            end
        end else if (have && e.at <= cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d missing output at cyc=%0d: got none, required flags=%b data=%h",
                     id, e.at, e.kind, e.data);
            if (id == 0) void'(qa.pop_front()); else void'(qb.pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, {err_timeout_a, err_sel_a, wd_valid_a}, wd_data_a);
        mon_step(1, {err_timeout_b, err_sel_b, wd_valid_b}, wd_data_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         busy_cnt;
    logic [2:0] bad_sel [2];

    initial begin
        reset_a = 1'b0; req_valid_a = 1'b0; req_sel_a = '0; flush_a = 1'b0;
        src_data_a = '0; src_valid_a = '0;
        reset_b = 1'b0; req_valid_b = 1'b0; req_sel_b = '0; flush_b = 1'b0;
        src_data_b = '0; src_valid_b = '0;
        repeat (3) step();
        reset_a = 1'b1;
        reset_b = 1'b1;

        check("a reset wd_data",   wd_data_a, 32'h0);
        check("a reset wd_valid",  32'(wd_valid_a), 32'h0);
        check("a reset busy",      32'(busy_a), 32'h0);
        check("a reset req_ready", 32'(req_ready_a), 32'h1);
        check("b reset wd_data",   wd_data_b, 32'h0);
        check("b reset req_ready", 32'(req_ready_b), 32'h1);

        // minimum-latency capture from HI, then an immediate back-to-back request
        src_data_a[SRC_HI*32 +: 32] = 32'hDEADBEEF;
        src_valid_a = 8'b0000_0100;
        req_valid_a = 1'b1;
        req_sel_a   = 3'(SRC_HI);
        qa.push_back('{K_WD, 32'hDEADBEEF, cyc + 2});
        step();
        req_valid_a = 1'b0;
        check("a busy in WAIT",      32'(busy_a), 32'h1);
        check("a not ready in WAIT", 32'(req_ready_a), 32'h0);
        step();
        check("a ready with wd_valid", 32'(req_ready_a), 32'h1);
        src_data_a[SRC_IMM*32 +: 32] = 32'h12345678;
        src_valid_a = 8'b0100_0000;
        req_valid_a = 1'b1;
        req_sel_a   = 3'(SRC_IMM);
        qa.push_back('{K_WD, 32'h12345678, cyc + 2});
        step();
        req_valid_a = 1'b0;
        step();

        // PC source turns valid in WAIT cycle 33 while other channels toggle
        src_valid_a = '0;
        src_data_a[SRC_PC*32 +: 32] = 32'h00000021;
        req_valid_a = 1'b1;
        req_sel_a   = 3'(SRC_PC);
        qa.push_back('{K_WD, 32'h00000021, cyc + 34});
        busy_cnt = 0;
        for (int i = 1; i <= 33; i++) begin
            step();
            req_valid_a = 1'b0;
            if (busy_a) busy_cnt++;
            for (int j = 0; j < 8; j++) begin
                if (j != SRC_PC) src_data_a[j*32 +: 32] = $urandom;
            end
            src_valid_a = 8'($urandom) & ~8'b0010_0000;
            if (i == 33) src_valid_a[SRC_PC] = 1'b1;
        end
        step();
        src_valid_a = '0;
        check("a busy cycle count", 32'(busy_cnt), 32'd33);
        check("a idle after capture", 32'(busy_a), 32'h0);

        // flush wins over a same-cycle capture
        src_data_a[SRC_ALU*32 +: 32] = 32'h0BAD0BAD;
        req_valid_a = 1'b1;
        req_sel_a   = 3'(SRC_ALU);
        step();
        req_valid_a = 1'b0;
        step();
        src_valid_a[SRC_ALU] = 1'b1;
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        src_valid_a = '0;
        check("a flush over capture busy", 32'(busy_a), 32'h0);
        check("a flush keeps wd_data", wd_data_a, 32'h00000021);

        // flush drops a request offered in IDLE
        flush_a     = 1'b1;
        req_valid_a = 1'b1;
        req_sel_a   = 3'(SRC_MEM);
        step();
        flush_a     = 1'b0;
        req_valid_a = 1'b0;
        check("a flush drops request busy", 32'(busy_a), 32'h0);
        check("a flush drops request ready", 32'(req_ready_a), 32'h1);

        // reset in WAIT cycle 5 on a source that never turns valid
        req_valid_a = 1'b1;
        req_sel_a   = 3'(SRC_LO);
        step();
        req_valid_a = 1'b0;
        repeat (3) step();
        step();
        reset_a = 1'b0;
        step();
        reset_a = 1'b1;
        check("a mid-WAIT reset busy", 32'(busy_a), 32'h0);
        check("a mid-WAIT reset ready", 32'(req_ready_a), 32'h1);
        check("a mid-WAIT reset wd_data", wd_data_a, 32'h0);

        // instance b: seed wd_data, then timeout, then capture in the last WAIT cycle
        src_data_b[0 +: 32] = 32'hA5A50000;
        src_valid_b = 6'b000001;
        req_valid_b = 1'b1;
        req_sel_b   = 3'd0;
        qb.push_back('{K_WD, 32'hA5A50000, cyc + 2});
        step();
        req_valid_b = 1'b0;
        step();
        step();
        src_valid_b = '0;

        req_valid_b = 1'b1;
        req_sel_b   = 3'd1;
        qb.push_back('{K_ET, 32'hA5A50000, cyc + 5});
        step();
        req_valid_b = 1'b0;
        repeat (3) step();
        check("b busy in last WAIT cycle", 32'(busy_b), 32'h1);
        step();
        check("b ready with err_timeout", 32'(req_ready_b), 32'h1);
        step();

        src_data_b[32 +: 32] = 32'h0B0B0B0B;
        req_valid_b = 1'b1;
        req_sel_b   = 3'd1;
        qb.push_back('{K_WD, 32'h0B0B0B0B, cyc + 5});
        step();
        req_valid_b = 1'b0;
        repeat (3) step();
        src_valid_b[1] = 1'b1;
        step();
        src_valid_b = '0;
        step();

        // out-of-range selectors, then the highest legal one
        bad_sel[0] = 3'd7;
        bad_sel[1] = 3'd6;
        for (int k = 0; k < 2; k++) begin
            req_valid_b = 1'b1;
            req_sel_b   = bad_sel[k];
            qb.push_back('{K_ES, 32'h0B0B0B0B, cyc + 1});
            step();
            req_valid_b = 1'b0;
            check("b ready after err_sel", 32'(req_ready_b), 32'h1);
            check("b idle after err_sel", 32'(busy_b), 32'h0);
            step();
        end

        src_data_b[5*32 +: 32] = 32'h00000055;
        src_valid_b = 6'b100000;
        req_valid_b = 1'b1;
        req_sel_b   = 3'd5;
        qb.push_back('{K_WD, 32'h00000055, cyc + 2});
        step();
        req_valid_b = 1'b0;
        step();
        step();
        src_valid_b = '0;

        repeat (4) step();
        check("a scoreboard drained", 32'(qa.size()), 32'h0);
        check("b scoreboard drained", 32'(qb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
